text_buffer_sequencer: RTL and testbench

Owns the write port of the 7x20 on-screen character buffer RAM and sequences every operation on it: single-cell glyph writes from the character feeder, whole-screen clears, and one-row scroll-up copies. Feeder events (write, scroll pulse, clear pulse) are queued in a small command FIFO and retired in program order. Multi-cycle clear and scroll sweeps therefore never lose or reorder characters. It sits between the character feeder and the dual-port character RAM that the VGA text renderer reads.

---
 rtl/text_pkg.sv | 39 +++
 rtl/text_cmd_fifo.sv | 67 ++++++
 rtl/text_buffer_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_text_buffer_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the on-screen text buffer.
// Holds the screen geometry, the blank glyph, the sequencer state encoding
// and the command word carried through the command FIFO.
package text_pkg;

  localparam int unsigned ROWS       = 7;
  localparam int unsigned COLS       = 20;
  localparam int unsigned ROW_W      = 4;
  localparam int unsigned COL_W      = 6;
  localparam int unsigned ID_W       = 8;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned CELLS      = ROWS * COLS;
  localparam int unsigned BLANK_ID   = 128;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCROLL_COPY,
    S_SCROLL_BLANK,
    S_WRITE
  } seq_state_t;

  // wr is only set for an in-range cell write; an out-of-range row/col
  // could otherwise alias onto a legal linear address.
  typedef struct packed {
    logic              clear;
    logic              scroll;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
  } text_cmd_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/text_cmd_fifo.sv
// Synchronous command FIFO.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   push, din       : write request and data; ignored when full unless a pop
//                     happens in the same cycle
//   pop, dout       : read request and head-of-queue data (dout shows the head)
//   full, empty     : occupancy flags
module text_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = store[rp];

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wp] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wp <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
      end
      if (do_pop) begin
        rp <= (rp == PTR_LAST) ? '0 : rp + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/text_buffer_sequencer.sv
// Write-port owner for the 7x20 character RAM.
// Queues feeder events (cell write, scroll pulse, clear pulse) and retires
// them in order: clear, then scroll (skipped if cleared), then cell write.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   wr_valid/wr_row/wr_col/wr_id : feeder cell write
//   scroll_req, clear_req      : one-cycle event pulses
//   wr_ready                   : command FIFO not full
//   busy                       : work queued or in progress (registered)
//   overflow                   : sticky, an event was dropped on a full FIFO
//   mem_raddr / mem_rdata      : RAM read port, 1-cycle latency
//   mem_we/mem_waddr/mem_wdata : RAM write port (registered)
module text_buffer_sequencer
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [ID_W-1:0]   wr_id,
  input  logic              scroll_req,
  input  logic              clear_req,
  output logic              wr_ready,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [ID_W-1:0]   mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ID_W-1:0]   mem_wdata
);

  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COPY_LAST  = ADDR_W'(CELLS - COLS);
  localparam logic [ADDR_W-1:0] READ_LAST  = ADDR_W'(CELLS - COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(COLS);
  localparam logic [ID_W-1:0]   BLANK      = ID_W'(BLANK_ID);

  seq_state_t        state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              pend_wr, pend_wr_n;
  logic [ADDR_W-1:0] pend_addr, pend_addr_n;
  logic [ID_W-1:0]   pend_id, pend_id_n;

  logic              we_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [ID_W-1:0]   wdata_n;
  logic [ADDR_W-1:0] raddr_n;
  logic              busy_c;

  text_cmd_t push_cmd;
  text_cmd_t head;
  logic      push_req;
  logic      in_range;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;

  assign push_req = wr_valid | scroll_req | clear_req;
  assign in_range = (wr_row < ROW_W'(ROWS)) && (wr_col < COL_W'(COLS));

  always_comb begin
    push_cmd        = '0;
    push_cmd.clear  = clear_req;
    push_cmd.scroll = scroll_req;
    push_cmd.wr     = wr_valid & in_range;
    push_cmd.addr   = cell_addr(wr_row, wr_col);
    push_cmd.id     = wr_id;
  end

  text_cmd_fifo #(
    .WIDTH($bits(text_cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_req),
    .pop  (fifo_pop),
    .din  (push_cmd),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign wr_ready = ~fifo_full;
  assign busy_c   = (state != S_IDLE) || !fifo_empty;

  // Each state computes the RAM port values for the following cycle. In
  // SCROLL_COPY the read for cnt is already on mem_raddr when cnt is entered
  // (IDLE issues the first one), so its data is on mem_rdata at cnt+1 and is
  // written to cnt one cycle after that; hence 121 steps for 120 copies.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pend_wr_n   = pend_wr;
    pend_addr_n = pend_addr;
    pend_id_n   = pend_id;
    fifo_pop    = 1'b0;
    we_n        = 1'b0;
    waddr_n     = mem_waddr;
    wdata_n     = mem_wdata;
    raddr_n     = mem_raddr;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          cnt_n       = '0;
          pend_wr_n   = head.wr;
          pend_addr_n = head.addr;
          pend_id_n   = head.id;
          if (head.clear) begin
            state_n = S_CLEAR;
          end else if (head.scroll) begin
            state_n = S_SCROLL_COPY;
            raddr_n = ROW_STRIDE;
          end else if (head.wr) begin
            state_n = S_WRITE;
          end
        end
      end

      S_CLEAR: begin
        we_n    = 1'b1;
        waddr_n = cnt;
        wdata_n = BLANK;
        if (cnt == LAST_CELL) begin
          state_n = pend_wr ? S_WRITE : S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_SCROLL_COPY: begin
        if (cnt < READ_LAST) begin
          raddr_n = cnt + ROW_STRIDE + 1'b1;
        end
        if (cnt != '0) begin
          we_n    = 1'b1;
          waddr_n = cnt - 1'b1;
          wdata_n = mem_rdata;
        end
        if (cnt == COPY_LAST) begin
          state_n = S_SCROLL_BLANK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_SCROLL_BLANK: begin
        we_n    = 1'b1;
        waddr_n = cnt;
        wdata_n = BLANK;
        if (cnt == LAST_CELL) begin
          state_n = pend_wr ? S_WRITE : S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_WRITE: begin
        we_n    = 1'b1;
        waddr_n = pend_addr;
        wdata_n = pend_id;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pend_wr   <= 1'b0;
      pend_addr <= '0;
      pend_id   <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_raddr <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pend_wr   <= pend_wr_n;
      pend_addr <= pend_addr_n;
      pend_id   <= pend_id_n;
      mem_we    <= we_n;
      mem_waddr <= waddr_n;
      mem_wdata <= wdata_n;
      mem_raddr <= raddr_n;
      busy      <= busy_c;
      if (push_req && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_text_buffer_sequencer.sv
`timescale 1ns/1ps
module tb_text_buffer_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [3:0] wr_row;
  logic [5:0] wr_col;
  logic [7:0] wr_id;
  logic       scroll_req;
  logic       clear_req;
  logic       wr_ready;
  logic       busy;
  logic       overflow;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  text_buffer_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_id     (wr_id),
    .scroll_req(scroll_req),
    .clear_req (clear_req),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .overflow  (overflow),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  // Character RAM model with a write log.
  logic [7:0] ram [256];
  logic       preload = 1'b0;
  int         cyc = 0;
  int         wl_addr[$];
  int         wl_data[$];
  int         wl_cyc[$];

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mem_rdata <= ram[mem_raddr];
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
    end else if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
      wl_addr.push_back(int'(mem_waddr));
      wl_data.push_back(int'(mem_wdata));
      wl_cyc.push_back(cyc);
    end
  end

  task automatic idle_inputs();
    wr_valid   = 1'b0;
    wr_row     = '0;
    wr_col     = '0;
    wr_id      = '0;
    scroll_req = 1'b0;
    clear_req  = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit done);
    done = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy && !mem_we) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %0b expected 0", mem_we); end
    tests_run++; if (mem_waddr !== 8'd0) begin tests_failed++; $display("FAIL reset_mem_waddr: got %0d expected 0", mem_waddr); end
    tests_run++; if (mem_wdata !== 8'd0) begin tests_failed++; $display("FAIL reset_mem_wdata: got %0d expected 0", mem_wdata); end
    tests_run++; if (mem_raddr !== 8'd0) begin tests_failed++; $display("FAIL reset_mem_raddr: got %0d expected 0", mem_raddr); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    wr_valid = 1'b1; wr_row = 4'd2; wr_col = 6'd3; wr_id = 8'd10;
    @(negedge clk);   // sampled at edge t
    idle_inputs();
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL wr_t0_we: got %0b expected 0", mem_we); end
    @(negedge clk);   // after t+1
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL wr_t1_we: got %0b expected 0", mem_we); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL wr_t1_busy: got %0b expected 1", busy); end
    @(negedge clk);   // after t+2
    tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL wr_t2_we: got %0b expected 1", mem_we); end
    tests_run++; if (mem_waddr !== 8'd43) begin tests_failed++; $display("FAIL wr_t2_waddr: got %0d expected 43", mem_waddr); end
    tests_run++; if (mem_wdata !== 8'd10) begin tests_failed++; $display("FAIL wr_t2_wdata: got %0d expected 10", mem_wdata); end
    @(negedge clk);   // after t+3
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL wr_t3_we: got %0b expected 0", mem_we); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wr_t3_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_clear();
    int start;
    int errs;
    bit done;
    start = wl_addr.size();
    clear_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    wait_done(400, done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL clear_done: got busy=%0b expected 0 within 400 cycles", busy); end
    tests_run++; if (wl_addr.size() - start != 140) begin tests_failed++; $display("FAIL clear_count: got %0d expected 140", wl_addr.size() - start); end
    if (wl_addr.size() - start >= 140) begin
      errs = 0;
      for (int i = 0; i < 140; i++)
        if (wl_addr[start+i] != i || wl_data[start+i] != 128) errs++;
      tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL clear_log: got %0d bad entries expected 0", errs); end
      tests_run++; if (wl_cyc[start+139] - wl_cyc[start] != 139) begin tests_failed++; $display("FAIL clear_contiguous: got span %0d expected 139", wl_cyc[start+139] - wl_cyc[start]); end
    end
    errs = 0;
    for (int i = 0; i < 140; i++) if (ram[i] !== 8'd128) errs++;
    tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL clear_ram: got %0d bad cells expected 0", errs); end
  endtask

  task automatic test_scroll();
    int start;
    int errs;
    int exp;
    bit done;
    do_preload();
    start = wl_addr.size();
    scroll_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    wait_done(400, done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL scroll_done: got busy=%0b expected 0 within 400 cycles", busy); end
    tests_run++; if (wl_addr.size() - start != 140) begin tests_failed++; $display("FAIL scroll_count: got %0d expected 140", wl_addr.size() - start); end
    if (wl_addr.size() - start >= 140) begin
      errs = 0;
      for (int i = 0; i < 140; i++) begin
        exp = (i < 120) ? i + 20 : 128;
        if (wl_addr[start+i] != i || wl_data[start+i] != exp) errs++;
      end
      tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL scroll_log: got %0d bad entries expected 0", errs); end
      tests_run++; if (wl_cyc[start+139] - wl_cyc[start] != 139) begin tests_failed++; $display("FAIL scroll_contiguous: got span %0d expected 139", wl_cyc[start+139] - wl_cyc[start]); end
    end
    errs = 0;
    for (int i = 0; i < 140; i++) begin
      exp = (i < 120) ? i + 20 : 128;
      if (ram[i] !== 8'(exp)) errs++;
    end
    tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL scroll_ram: got %0d bad cells expected 0", errs); end
    tests_run++; if (ram[119] !== 8'd139) begin tests_failed++; $display("FAIL scroll_ram119: got %0d expected 139", ram[119]); end
  endtask

  task automatic test_scroll_write();
    int start;
    bit done;
    do_preload();
    start = wl_addr.size();
    scroll_req = 1'b1;
    wr_valid = 1'b1; wr_row = 4'd6; wr_col = 6'd0; wr_id = 8'd5;
    @(negedge clk);
    idle_inputs();
    wait_done(400, done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL scrwr_done: got busy=%0b expected 0 within 400 cycles", busy); end
    tests_run++; if (wl_addr.size() - start != 141) begin tests_failed++; $display("FAIL scrwr_count: got %0d expected 141", wl_addr.size() - start); end
    if (wl_addr.size() - start >= 141) begin
      tests_run++; if (wl_addr[start+140] != 120 || wl_data[start+140] != 5) begin tests_failed++; $display("FAIL scrwr_last: got addr %0d data %0d expected addr 120 data 5", wl_addr[start+140], wl_data[start+140]); end
      tests_run++; if (wl_cyc[start+140] - wl_cyc[start] != 140) begin tests_failed++; $display("FAIL scrwr_contiguous: got span %0d expected 140", wl_cyc[start+140] - wl_cyc[start]); end
    end
    tests_run++; if (ram[120] !== 8'd5) begin tests_failed++; $display("FAIL scrwr_ram120: got %0d expected 5", ram[120]); end
    tests_run++; if (ram[0] !== 8'd20) begin tests_failed++; $display("FAIL scrwr_ram0: got %0d expected 20", ram[0]); end
    tests_run++; if (ram[139] !== 8'd128) begin tests_failed++; $display("FAIL scrwr_ram139: got %0d expected 128", ram[139]); end
  endtask

  task automatic test_overflow();
    int start;
    int errs;
    bit done;
    start = wl_addr.size();
    clear_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_row = 4'd1; wr_col = 6'(i); wr_id = 8'(i + 1);
      @(negedge clk);
      if (i == 2) begin
        tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL ovf_ready3: got %0b expected 1", wr_ready); end
      end
      if (i == 3) begin
        tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL ovf_ready4: got %0b expected 0", wr_ready); end
      end
    end
    idle_inputs();
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    wait_done(600, done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL ovf_done: got busy=%0b expected 0 within 600 cycles", busy); end
    tests_run++; if (wl_addr.size() - start != 144) begin tests_failed++; $display("FAIL ovf_count: got %0d expected 144", wl_addr.size() - start); end
    if (wl_addr.size() - start >= 144) begin
      errs = 0;
      for (int i = 0; i < 4; i++)
        if (wl_addr[start+140+i] != 20 + i || wl_data[start+140+i] != i + 1) errs++;
      tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL ovf_order: got %0d bad entries expected 0", errs); end
    end
    tests_run++; if (ram[24] !== 8'd128) begin tests_failed++; $display("FAIL ovf_dropped: got %0d expected 128", ram[24]); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
  endtask

  task automatic test_reset_mid_sweep();
    int start;
    int after;
    bit found;
    start = wl_addr.size();
    clear_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    wr_valid = 1'b1; wr_row = 4'd0; wr_col = 6'd0; wr_id = 8'd77;
    @(negedge clk);
    wr_col = 6'd1; wr_id = 8'd78;
    @(negedge clk);
    idle_inputs();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wl_addr.size() - start >= 50) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL rst_mid_reach50: got %0d writes expected 50 within 200 cycles", wl_addr.size() - start); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_we: got %0b expected 0", mem_we); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %0b expected 0", busy); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_overflow: got %0b expected 0", overflow); end
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready: got %0b expected 1", wr_ready); end
    reset = 1'b0;
    after = wl_addr.size();
    repeat (20) @(negedge clk);
    tests_run++; if (wl_addr.size() != after) begin tests_failed++; $display("FAIL rst_mid_fifo_empty: got %0d extra writes expected 0", wl_addr.size() - after); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy_after: got %0b expected 0", busy); end
    tests_run++; if (ram[0] !== 8'd128) begin tests_failed++; $display("FAIL rst_mid_ram0: got %0d expected 128", ram[0]); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single_write();
    test_clear();
    test_scroll();
    test_scroll_write();
    test_overflow();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
